// File: rtl/spi_xfer_seq.sv
// spi_xfer_seq: burst sequencer that drives an SPI core register port (cmd/tx/rx streams in, core writes out)
module spi_xfer_seq #(
  parameter int S = 2,
  parameter int SW = (S > 1) ? $clog2(S) : 1,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [SW-1:0] cmd_slave,
  input  logic [LW-1:0] cmd_len,
  input  logic [15:0]   cmd_dvsr,
  input  logic          cmd_cpol,
  input  logic          cmd_cpha,
  input  logic          tx_valid,
  output logic          tx_ready,
  input  logic [7:0]    tx_data,
  output logic          rx_valid,
  input  logic          rx_ready,
  output logic [7:0]    rx_data,
  output logic          done,
  output logic          err,
  output logic          core_write,
  output logic [1:0]    core_instr,
  output logic [31:0]   core_wr_data,
  input  logic [31:0]   core_rd_data
);
  typedef enum logic [3:0] {IDLE, CFG, SEL, WTX, SEND, GRD, BUSY, RXO, DSEL, FIN} state_t;
  state_t state, nxt;
  logic [SW-1:0] slave;
  logic [15:0] dvsr;
  logic cpol, cpha, bad;
  logic [7:0] tx_byte;
  logic [LW:0] remaining;
  logic slave_ok;
  logic [31:0] all_ss;
  logic unused_rd;
  assign unused_rd = ^core_rd_data[31:9];
  assign slave_ok = {1'b0, cmd_slave} < (SW+1)'(S);
  assign all_ss = {{(32-S){1'b0}}, {S{1'b1}}};
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = cmd_valid ? (slave_ok ? CFG : FIN) : IDLE;
      CFG:     nxt = SEL;
      SEL:     nxt = WTX;
      WTX:     nxt = tx_valid ? SEND : WTX;
      SEND:    nxt = GRD;
      GRD:     nxt = BUSY;
      BUSY:    nxt = core_rd_data[8] ? RXO : BUSY;
      RXO:     nxt = rx_ready ? ((remaining != '0) ? WTX : DSEL) : RXO;
      DSEL:    nxt = FIN;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cmd_ready  <= 1'b1;
      tx_ready   <= 1'b0;
      rx_valid   <= 1'b0;
      core_write <= 1'b0;
      rx_data    <= '0;
      remaining  <= '0;
      slave      <= '0;
      dvsr       <= '0;
      cpol       <= 1'b0;
      cpha       <= 1'b0;
      bad        <= 1'b0;
      tx_byte    <= '0;
    end else begin
      state      <= nxt;
      cmd_ready  <= nxt == IDLE;
      tx_ready   <= nxt == WTX;
      rx_valid   <= nxt == RXO;
      core_write <= nxt inside {CFG, SEL, SEND, DSEL};
      if (state == IDLE && cmd_valid) begin
        slave     <= cmd_slave;
        dvsr      <= cmd_dvsr;
        cpol      <= cmd_cpol;
        cpha      <= cmd_cpha;
        bad       <= !slave_ok;
        remaining <= {cmd_len == '0, cmd_len};
      end
      if (state == WTX && tx_valid) tx_byte <= tx_data;
      if (state == BUSY && core_rd_data[8]) begin
        rx_data   <= core_rd_data[7:0];
        remaining <= remaining - (LW+1)'(1);
      end
    end
  end
  always_comb begin
    core_instr   = (state == CFG) ? 2'b11 : (state == SEND) ? 2'b10 : (state == SEL || state == DSEL) ? 2'b01 : 2'b00;
    core_wr_data = (state == CFG)  ? {14'b0, cpha, cpol, dvsr} :
                   (state == SEL)  ? (all_ss & ~(32'd1 << slave)) :
                   (state == SEND) ? {24'b0, tx_byte} :
                   (state == DSEL) ? all_ss : 32'b0;
    done         = state == FIN;
    err          = state == FIN && bad;
  end
endmodule

// File: doc/spi_xfer_seq.md
# spi_xfer_seq

Transfer sequencer that sits directly upstream of the SPI core's register interface. It accepts a burst command (slave index, byte count, clock config) and drives the core's `write`/`instr`/`wr_data` port. It sends each TX byte, polls the core's ready bit and returns each received byte on an RX stream, so software or a DMA sees whole-burst transactions instead of register pokes.

## Interface
- `S`, 2: number of slaves; must match the SPI core's `S`.
- `SW`, max(1, $clog2(S)): width of the slave index.
- `LW`, 8: width of the byte count.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_slave`  in  SW  target slave index.
- `cmd_len`  in  LW  byte count; 0 means 2^LW.
- `cmd_dvsr`  in  16  SCLK divisor.
- `cmd_cpol`, `cmd_cpha`  in  1 each  SPI mode.
- `tx_valid`, `tx_ready`  in/out  1 each  TX byte handshake.
- `tx_data`  in  8  TX byte.
- `rx_valid`, `rx_ready`  out/in  1 each  RX byte handshake.
- `rx_data`  out  8  RX byte.
- `done`  out  1  one-cycle pulse at burst end.
- `err`  out  1  valid with `done`; 1 = slave index out of range.
- `core_write`  out  1  one-cycle register-write strobe to the core.
- `core_instr`  out  2  register select: 01 = SS, 10 = SPI data/start, 11 = CTRL.
- `core_wr_data`  out  32  register write data.
- `core_rd_data`  in  32  core status: [8] = ready, [7:0] = last RX byte.

## Operation
Command accept: on `cmd_valid && cmd_ready`, latch all cmd fields and load `remaining` with `cmd_len`; a `cmd_len` of 0 loads 2^LW.

FSM states:
- **IDLE**: `cmd_ready`=1. On accept, go to CFG if `cmd_slave` < S; otherwise go to FIN with `err` set.
- **CFG**: `core_write`=1, `core_instr`=11, `core_wr_data`={14'b0, cpha, cpol, dvsr}. Go to SEL.
- **SEL**: `core_write`=1, `core_instr`=01.
  - `core_wr_data[S-1:0]` = all ones with bit `cmd_slave` cleared; upper bits 0.
  - Go to WTX.
- **WTX**: `tx_ready`=1. On `tx_valid`, capture `tx_data` and go to SEND.
- **SEND**: `core_write`=1, `core_instr`=10, `core_wr_data`={24'b0, byte}. Go to GRD.
- **GRD**: one wait cycle, because the core's ready bit lags start by up to one cycle. Go to BUSY.
- **BUSY**: wait for `core_rd_data[8]`=1. Then register `core_rd_data[7:0]` into `rx_data`, decrement `remaining`, and go to RXO.
- **RXO**: `rx_valid`=1 and held stable until `rx_ready`.
  - On the handshake, go to WTX if `remaining` != 0, else go to DSEL.
- **DSEL**: `core_write`=1, `core_instr`=01, `core_wr_data`={(32-S)'b0, {S{1'b1}}}. Go to FIN.
- **FIN**: `done`=1 for one cycle; `err` as latched. Go to IDLE.

Rules:
- Outside the write states listed above, `core_write`=0, `core_instr`=00 and `core_wr_data`=0.
- At most one core write per cycle; writes are never back-to-back with the same `instr`.
- `tx_ready`, `rx_valid`, `cmd_ready` and `core_write` are registered decodes of the state.
- `cmd_valid` while not IDLE is ignored; `cmd_ready`=0.
- Arithmetic: `remaining` is LW+1 bits. The decrement happens only in BUSY→RXO, so it never underflows.
- An err burst issues no core writes and consumes no TX bytes.

## Timing
- Reset (`rst_n`=0 at a `clk` edge): the state goes to IDLE.
  - `cmd_ready`=1; `tx_ready`, `rx_valid`, `done`, `err`, `core_write` all 0; `core_instr`=00; `core_wr_data`=0; `rx_data`=0.
  - A mid-burst reset abandons the burst immediately with no DSEL write; the SPI core is reset by the same system reset.
- Accept → CFG strobe: 1 cycle. CFG → SEL: 1 cycle. SEL → `tx_ready`: 1 cycle.
- `tx_valid` seen in WTX → SEND strobe on the next cycle.
- SEND → earliest `rx_valid`: 3 cycles (GRD, then BUSY seeing ready=1).
- `rx_ready` handshake → `tx_ready` on the next cycle.
- Last RX handshake → DSEL strobe on the next cycle → `done` on the cycle after.
- Err path: accept → `done`=`err`=1 on the next cycle.
- The block never stalls the core. Backpressure is absorbed by holding state: RX is held in RXO, and TX waits in WTX with the slave still selected.

## Test plan
- **Reset values**: hold `rst_n`=0 for 3 cycles → every output equals its reset value and `cmd_ready`=1; release → no `core_write` until a command is accepted.
- **Single byte**: S=2, slave 0, len 1, dvsr 4, cpol 0, cpha 1, tx 0xA5; the core model returns 0x3C after 20 cycles → core writes in this order:
  - (11, 0x00020004)
  - (01, 0x00000002)
  - (10, 0x000000A5)
  - (01, 0x00000003)
  - `rx_data`=0x3C; one `done` pulse with `err`=0.
- **Three bytes with backpressure**: slave 1, len 3, tx 0x11/0x22/0x33 with 2-cycle gaps on `tx_valid`, `rx_ready` low for 5 cycles on byte 2 → SS=0x00000001 is written once and stays asserted; RX bytes arrive in order; `rx_data` is stable while stalled; exactly 3 SEND strobes.
- **Length wrap**: `cmd_len`=0 with LW=8 → exactly 256 SEND strobes and 256 RX bytes, then DSEL and `done`.
- **Bad slave**: S=3, SW=2, `cmd_slave`=3 → zero core writes; `tx_ready` never rises; `done`=`err`=1 one cycle after accept.
- **Reset mid-burst**: drop `rst_n` during BUSY of byte 2 of 4 → next cycle IDLE with reset outputs; no DSEL write; a new command then runs from CFG normally.
